until_monitor: RTL
==================

// Module: until_monitor
// PURPOSE
//   Synthesizable run-time checker placed directly downstream of the trace sequencer.
//   Consumes its A/B/C/D outputs and evaluates "rose(A) |=> B ##DELAY C until[_with] D[*D_RUN]" in RTL.
//   Reports per-attempt pass/fail pulses with a failure code and saturating statistics.
//   Used to cross-check formal results in simulation and on hardware.
// PARAMETERS
//   DELAY     2   cycles from the B check cycle to the first C/D watch cycle (>=1)
//   D_RUN     2   consecutive cycles of D that terminate the watch (>=1)
//   WITH      0   0: until (C not required on completing cycle); 1: until_with (C required)
//   MAX_WAIT  16  watch cycles allowed before timeout failure (>=D_RUN)
// PORTS
//   clock     in   1  rising-edge clock
//   reset     in   1  asynchronous, active-high reset
//   a         in   1  trigger signal (rising edge starts an attempt)
//   b         in   1  antecedent-follow signal
//   c         in   1  hold signal
//   d         in   1  release signal
//   busy      out  1  attempt in progress (state != IDLE)
//   pass      out  1  one-cycle pulse: attempt completed successfully
//   fail      out  1  one-cycle pulse: attempt failed
//   fail_code out  2  1=B missing, 2=C dropped, 3=timeout; holds last code, 0 until first fail
//   attempts  out  8  started attempts, saturating at 255
//   fails     out  8  failed attempts, saturating at 255
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, a_q=0, counters 0. a high on the first edge after reset counts as a rise.
//   - rose(A) at edge t: a==1 && a_q==0. a_q <= a on every edge.
//   - States and transitions:
//     - IDLE:  on rose(A) -> ARM; attempts++.
//     - ARM:   edge t+1. If !b -> fail, code 1, IDLE. If b: DELAY>1 -> WAIT, else -> WATCH.
//     - WAIT:  counts DELAY-1 edges (t+2 .. t+DELAY). No checks. Then -> WATCH.
//     - WATCH: from edge t+1+DELAY on, per edge:
//         run_n = d ? run+1 : 0.
//         If run_n==D_RUN: pass when (WITH==0 || c); else fail, code 2. -> IDLE.
//         Else if !c: fail, code 2, IDLE.
//         Else if watch count reaches MAX_WAIT: fail, code 3, IDLE.
//   - Outputs are registered: pass/fail assert the cycle after the deciding edge, 1 cycle wide, never both.
//   - Overlap: rose(A) while busy is ignored and not counted. No pipelining of attempts.
//   - Same-edge events: a rise on the edge where an attempt completes is ignored.
//     It is caught only if A rises again later.
//   - Counters:
//     - fails increments with every fail pulse.
//     - Both counters hold at 255.
//     - Counters are not cleared by attempt completion, only by reset.
//   - Reset mid-attempt: immediate abort, no pass/fail pulse, state IDLE.
//   - Widths: run counter clog2(D_RUN+1) bits; watch counter clog2(MAX_WAIT+1) bits; no wrap inside limits.
// TESTING
//   - T1 default params:
//     - A=_-___, B high 2-5, C high 4-7, D high 5-6.
//     - Expect pass pulse at cycle 7, attempts=1, fails=0.
//   - T2 same as T1 but D high at 4 and 6 only:
//     - run never reaches 2; C drops at 8.
//     - Expect fail at cycle 9, code 2.
//   - T3 WITH=1, T1 traces:
//     - C high on completing cycle 6.
//     - Expect pass. Then with C high only 4-5: expect fail code 2 at cycle 7.
//   - T4 B low at cycle 2 after A rise at 1 -> fail at cycle 3, code 1, fails=1.
//   - T5 MAX_WAIT=4, C held high, D low -> fail code 3 four watch edges after entry.
//   - T6 A pulsed at 1 and 3:
//     - second rise ignored, attempts=1.
//     - reset asserted at cycle 4 -> all outputs 0, no pulse.

Source files
------------

// File: rtl/until_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : until_monitor
//  Description : Run-time checker for
//                "rose(A) |=> B ##DELAY C until[_with] D[*D_RUN]".
//                Emits one-cycle pass/fail pulses, the last failure code and
//                saturating attempt/fail statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module until_monitor #(
    parameter int DELAY    = 2,   // B check cycle to first C/D watch cycle (>=1)
    parameter int D_RUN    = 2,   // consecutive D cycles that end the watch (>=1)
    parameter int WITH     = 0,   // 0: until, 1: until_with (C needed on last cycle)
    parameter int MAX_WAIT = 16   // watch cycles before timeout (>=D_RUN)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [1:0] fail_code,
    output logic [7:0] attempts,
    output logic [7:0] fails
);

    localparam int c_run_w   = $clog2(D_RUN + 1);
    localparam int c_watch_w = $clog2(MAX_WAIT + 1);
    localparam int c_wait_w  = $clog2(DELAY + 1);

    localparam logic [c_run_w-1:0]   c_run_one    = c_run_w'(1);
    localparam logic [c_run_w-1:0]   c_run_goal   = c_run_w'(D_RUN);
    localparam logic [c_watch_w-1:0] c_watch_one  = c_watch_w'(1);
    localparam logic [c_watch_w-1:0] c_watch_goal = c_watch_w'(MAX_WAIT);
    localparam logic [c_wait_w-1:0]  c_wait_one   = c_wait_w'(1);
    localparam logic [c_wait_w-1:0]  c_wait_goal  = c_wait_w'(DELAY - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_arm   = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_watch = 2'd3;

    localparam logic [1:0] c_code_b_missing = 2'd1;
    localparam logic [1:0] c_code_c_dropped = 2'd2;
    localparam logic [1:0] c_code_timeout   = 2'd3;

    logic [1:0]           r_state;
    logic                 r_a_q;
    logic [c_run_w-1:0]   r_run;
    logic [c_watch_w-1:0] r_watch;
    logic [c_wait_w-1:0]  r_wait;

    logic                 w_rose;
    logic [c_run_w-1:0]   w_run_n;
    logic [c_watch_w-1:0] w_watch_n;
    logic                 w_pass_now;
    logic                 w_fail_now;
    logic [1:0]           w_code_now;

    assign w_rose    = a & ~r_a_q;
    assign w_run_n   = d ? (r_run + c_run_one) : '0;
    assign w_watch_n = r_watch + c_watch_one;
    assign busy      = (r_state != c_st_idle);

    // Decide whether the current edge ends the attempt, and how.
    always_comb begin
        w_pass_now = 1'b0;
        w_fail_now = 1'b0;
        w_code_now = 2'd0;
        case (r_state)
            c_st_arm: begin
                if (!b) begin
                    w_fail_now = 1'b1;
                    w_code_now = c_code_b_missing;
                end
            end
            c_st_watch: begin
                if (w_run_n == c_run_goal) begin
                    // Release seen; until_with additionally needs C on this cycle.
                    if ((WITH == 0) || c) begin
                        w_pass_now = 1'b1;
                    end else begin
                        w_fail_now = 1'b1;
                        w_code_now = c_code_c_dropped;
                    end
                end else if (!c) begin
                    w_fail_now = 1'b1;
                    w_code_now = c_code_c_dropped;
                end else if (w_watch_n == c_watch_goal) begin
                    w_fail_now = 1'b1;
                    w_code_now = c_code_timeout;
                end
            end
            default: ;
        endcase
    end

    // Attempt sequencer, registered verdict pulses and saturating statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_a_q     <= 1'b0;
            r_run     <= '0;
            r_watch   <= '0;
            r_wait    <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
            attempts  <= 8'd0;
            fails     <= 8'd0;
        end else begin
            r_a_q <= a;
            pass  <= w_pass_now;
            fail  <= w_fail_now;
            if (w_fail_now) begin
                fail_code <= w_code_now;
                if (fails != 8'hFF) begin
                    fails <= fails + 8'd1;
                end
            end
            case (r_state)
                c_st_idle: begin
                    // A rise while busy never reaches this state, so it is dropped.
                    if (w_rose) begin
                        r_state <= c_st_arm;
                        if (attempts != 8'hFF) begin
                            attempts <= attempts + 8'd1;
                        end
                    end
                end
                c_st_arm: begin
                    r_run   <= '0;
                    r_watch <= '0;
                    r_wait  <= c_wait_one;
                    if (w_fail_now) begin
                        r_state <= c_st_idle;
                    end else if (DELAY > 1) begin
                        r_state <= c_st_wait;
                    end else begin
                        r_state <= c_st_watch;
                    end
                end
                c_st_wait: begin
                    if (r_wait == c_wait_goal) begin
                        r_state <= c_st_watch;
                    end else begin
                        r_wait <= r_wait + c_wait_one;
                    end
                end
                default: begin
                    r_run   <= w_run_n;
                    r_watch <= w_watch_n;
                    if (w_pass_now || w_fail_now) begin
                        r_state <= c_st_idle;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
